// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage MIPS32 core.
// It drives the operand-forwarding selects for execute and decode, and the
// stall/flush controls for load-use, branch-compare and mult/div hazards.
// A small FSM with a down-counter tracks the multi-cycle mult/div unit.
module hazard_unit #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_e,
    input  logic [4:0] write_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_e,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       mem_to_reg_e,
    input  logic       mem_to_reg_m,
    input  logic       branch_d,
    input  logic       md_start_d,
    input  logic       md_read_d,
    input  logic       md_start_e,
    input  logic       md_op_e,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       forward_a_d,
    output logic       forward_b_d,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_e,
    output logic       md_busy
);

    localparam logic [1:0] FwdRegfile = 2'b00;
    localparam logic [1:0] FwdWb      = 2'b01;
    localparam logic [1:0] FwdMem     = 2'b11;

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

    md_state_e        state;
    logic [CNT_W-1:0] cnt;

    logic lw_stall;
    logic br_stall;
    logic md_stall;
    logic md_busy_eff;

    // Execute-stage operand selects; memory stage has priority as it is younger.
    always_comb begin
        forward_a_e = FwdRegfile;
        forward_b_e = FwdRegfile;
        if (rs_e != 5'd0 && reg_write_m && write_reg_m == rs_e) begin
            forward_a_e = FwdMem;
        end else if (rs_e != 5'd0 && reg_write_w && write_reg_w == rs_e) begin
            forward_a_e = FwdWb;
        end
        if (rt_e != 5'd0 && reg_write_m && write_reg_m == rt_e) begin
            forward_b_e = FwdMem;
        end else if (rt_e != 5'd0 && reg_write_w && write_reg_w == rt_e) begin
            forward_b_e = FwdWb;
        end
    end

    // Decode-stage branch-compare selects and the three stall sources.
    always_comb begin
        forward_a_d = (rs_d != 5'd0) && reg_write_m && (write_reg_m == rs_d);
        forward_b_d = (rt_d != 5'd0) && reg_write_m && (write_reg_m == rt_d);

        lw_stall = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));

        br_stall = branch_d &&
                   ((reg_write_e && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                    (mem_to_reg_m && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));

        // A busy unit held in reset is about to be cleared, so it must not stall.
        md_busy_eff = md_busy && reset_n;
        md_stall    = (md_read_d || md_start_d) && (md_busy_eff || md_start_e);

        stall_f = lw_stall || br_stall || md_stall;
        stall_d = stall_f;
        flush_e = stall_f;
    end

    // Mult/div occupancy FSM; md_busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= StIdle;
            cnt     <= '0;
            md_busy <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (md_start_e) begin
                        state   <= StBusy;
                        cnt     <= md_op_e ? DivLoad : MultLoad;
                        md_busy <= 1'b1;
                    end
                end
                StBusy: begin
                    // A start seen here is ignored; the running count continues.
                    if (cnt <= CntOne) begin
                        state   <= StIdle;
                        cnt     <= '0;
                        md_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                default: begin
                    state   <= StIdle;
                    cnt     <= '0;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS32 core. It generates the 2-bit select codes for the execute-stage 3-input operand muxes and the 1-bit selects for the decode-stage branch-compare 2-input muxes. It also raises the stall and flush controls for load-use and branch hazards, and tracks a multi-cycle multiply/divide unit with a down-counter so HI/LO consumers stall until the result is ready.

## Interface
- MULT_CYCLES, 4, busy cycles for a multiply (≥1)
- DIV_CYCLES, 32, busy cycles for a divide (≥1, ≥ MULT_CYCLES)
- CNT_W, 6, counter width; must hold DIV_CYCLES
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- rs_d, rt_d  in  5  decode-stage source registers
- rs_e, rt_e  in  5  execute-stage source registers
- write_reg_e, write_reg_m, write_reg_w  in  5  destination register per stage
- reg_write_e, reg_write_m, reg_write_w  in  1  stage writes register file
- mem_to_reg_e, mem_to_reg_m  in  1  stage holds a load
- branch_d  in  1  decode holds a branch
- md_start_d, md_read_d  in  1  decode holds mult/div start / mfhi-mflo
- md_start_e  in  1  mult/div issues this cycle
- md_op_e  in  1  0 = multiply, 1 = divide
- forward_a_e, forward_b_e  out  2  execute mux select: 00 regfile, 01 writeback result, 11 memory-stage ALU result
- forward_a_d, forward_b_d  out  1  decode mux select: 1 = memory-stage ALU result
- stall_f, stall_d, flush_e  out  1  hold PC / hold IF-ID / bubble ID-EX
- md_busy  out  1  mult/div result not yet valid (registered)

## Operation
- Execute forwarding (A shown; B uses rt_e):
  - 11 if rs_e≠0, reg_write_m, and write_reg_m==rs_e.
  - Else 01 if rs_e≠0, reg_write_w, and write_reg_w==rs_e.
  - Else 00.
  - Code 10 is never driven. Memory-stage priority wins when both match.
- Decode forwarding: forward_a_d = rs_d≠0 & reg_write_m & write_reg_m==rs_d. forward_b_d is the same with rt_d.
- lw_stall = mem_to_reg_e & (rt_e==rs_d | rt_e==rt_d).
- br_stall = branch_d & (reg_write_e & (write_reg_e==rs_d | write_reg_e==rt_d) | mem_to_reg_m & (write_reg_m==rs_d | write_reg_m==rt_d)).
- md_stall = (md_read_d | md_start_d) & (md_busy | md_start_e).
- stall_f = stall_d = flush_e = lw_stall | br_stall | md_stall.
- Mult/div FSM (states IDLE, BUSY; count register cnt):
  - IDLE: when md_start_e=1, load cnt = md_op_e ? DIV_CYCLES : MULT_CYCLES and go to BUSY.
  - BUSY: cnt decrements by 1 each cycle. On the edge where cnt==1, cnt becomes 0 and the FSM returns to IDLE.
  - md_busy = (state==BUSY).
  - md_start_e while BUSY is ignored and the count continues (md_stall makes this unreachable; the bench asserts on it).
- Reset (reset_n=0 at a rising edge): state=IDLE, cnt=0, md_busy=0, with priority over all other inputs, including mid-operation.
- While reset_n=0, combinational outputs still follow their equations, but md_busy contributes 0.

## Timing
- Forward selects and stall_f/stall_d/flush_e are combinational from the current-cycle inputs, with zero latency.
- md_busy is registered.
  - Start sampled at edge t → md_busy=1 for edges t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES), then 0 after edge t+N+1.
  - It is high for exactly N cycles.
- In the start cycle itself (md_start_e=1, md_busy=0), a decode-stage md_read_d already stalls via the md_start_e term.
- A stall held across multiple cycles keeps flush_e asserted every cycle the condition holds.
- Reset values: md_busy=0. With all inputs 0, forward_* = 00/0 and stall_f = stall_d = flush_e = 0.

## Test plan
- Forward priority: rs_e=5, write_reg_m=5, reg_write_m=1, write_reg_w=5, reg_write_w=1 → forward_a_e=11. Drop reg_write_m → 01. Set rs_e=0 → 00. Code 10 never observed.
- Load-use: mem_to_reg_e=1, rt_e=8, rs_d=8 → stall_f=stall_d=flush_e=1. Change rs_d=9, rt_d=9 → all 0.
- Branch hazard: branch_d=1, reg_write_e=1, write_reg_e=3, rt_d=3 → stall=1. Same case with write_reg_m=3, mem_to_reg_m=1 instead → stall=1. With write_reg_m=3, reg_write_m=1, mem_to_reg_m=0 → stall=0 and forward_b_d=1.
- Divide busy: md_start_e=1, md_op_e=1 for one cycle → md_busy high exactly 32 cycles. md_read_d=1 throughout → stall=1 from the start cycle through the last busy cycle, then 0.
- Multiply busy: md_op_e=0 → md_busy high exactly 4 cycles. Back-to-back md_start_d during busy → stall held.
- Reset mid-op: reset_n=0 for one edge at busy cycle 10 of a divide → md_busy=0 next cycle, cnt=0. A new start then yields a full N-cycle busy.
